// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I-subset core: IF/ID/EX/MEM/WB sequencing
// with combinational (Moore plus Zero/dReady Mealy) datapath and memory strobes.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        dReady,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  logic [2:0] state_q, state_d;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       f7_q;

  // Only the decode-relevant instruction fields are kept in the IR
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
      f7_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF) begin
        op_q <= instr[6:0];
        f3_q <= instr[14:12];
        f7_q <= instr[30];
      end
    end
  end

  logic is_r, is_i, is_lw, is_sw, is_beq, legal;
  logic [3:0] alu_dec;
  logic       src_dec;

  assign is_r   = (op_q == OP_R);
  assign is_i   = (op_q == OP_I);
  assign is_lw  = (op_q == OP_LW)  && (f3_q == 3'b010);
  assign is_sw  = (op_q == OP_SW)  && (f3_q == 3'b010);
  assign is_beq = (op_q == OP_BEQ) && (f3_q == 3'b000);
  // SLTU/SLTIU share funct3 011 and are not supported
  assign legal  = ((is_r || is_i) && (f3_q != 3'b011)) || is_lw || is_sw || is_beq;
  assign src_dec = legal && (is_i || is_lw || is_sw);

  always_comb begin
    alu_dec = ALU_AND;
    if (is_beq) begin
      alu_dec = ALU_SUB;
    end else if (is_lw || is_sw) begin
      alu_dec = ALU_ADD;
    end else if (legal) begin
      case (f3_q)
        3'b000:  alu_dec = (is_r && f7_q) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_dec = ALU_SLL;
        3'b010:  alu_dec = ALU_SLT;
        3'b100:  alu_dec = ALU_XOR;
        3'b101:  alu_dec = f7_q ? ALU_SRA : ALU_SRL;
        3'b110:  alu_dec = ALU_OR;
        3'b111:  alu_dec = ALU_AND;
        default: alu_dec = ALU_AND;
      endcase
    end
  end

  always_comb begin
    state_d  = S_IF;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    loadPC   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    illegal  = 1'b0;
    ALUCtrl  = 4'd0;
    ALUSrc   = 1'b0;
    if (state_q == S_ID || state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
      ALUCtrl = alu_dec;
      ALUSrc  = src_dec;
    end
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (legal) begin
          state_d = S_EX;
        end else begin
          illegal = 1'b1;
          loadPC  = 1'b1;
        end
      end
      S_EX: begin
        if (is_beq) begin
          loadPC = 1'b1;
          PCSrc  = Zero;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (!dReady) begin
          state_d = S_MEM;
        end else if (is_lw) begin
          state_d = S_WB;
        end else begin
          loadPC = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        loadPC   = 1'b1;
        MemToReg = is_lw;
      end
      default: state_d = S_IF;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: each instruction's expected
// state trace and strobes are built from its class, then compared cycle by cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        Zero;
  logic        dReady;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .dReady(dReady),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction class: 0 R/I-ALU, 1 LW, 2 SW, 3 BEQ, 4 illegal
  function automatic int classify(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    if ((op == 7'b0110011 || op == 7'b0010011) && f3 != 3'b011) return 0;
    if (op == 7'b0000011 && f3 == 3'b010) return 1;
    if (op == 7'b0100011 && f3 == 3'b010) return 2;
    if (op == 7'b1100011 && f3 == 3'b000) return 3;
    return 4;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (classify(ins))
      1, 2: return 4'b0010;
      3:    return 4'b0110;
      0: begin
        case (f3)
          3'b000: return (ins[6:0] == 7'b0110011 && ins[30]) ? 4'b0110 : 4'b0010;
          3'b001: return 4'b1001;
          3'b010: return 4'b0100;
          3'b100: return 4'b0101;
          3'b101: return ins[30] ? 4'b1010 : 4'b1000;
          3'b110: return 4'b0001;
          default: return 4'b0000;
        endcase
      end
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int sel;
    ins = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1: ins[6:0] = 7'b0110011;
      2, 3: ins[6:0] = 7'b0010011;
      4: begin ins[6:0] = 7'b0000011; ins[14:12] = 3'b010; end
      5: begin ins[6:0] = 7'b0100011; ins[14:12] = 3'b010; end
      6: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b000; end
      7: ins[6:0] = ($urandom_range(0, 1) == 1) ? 7'b0000011 : 7'b1100011;
      default: ;
    endcase
    return ins;
  endfunction

  // Called at posedge+1 of an IF cycle; returns at posedge+1 of the next IF cycle
  task automatic run_instr(input logic [31:0] ins, input logic zero_v, input int waits);
    int cls;
    int seq[$];
    int mem_idx;
    int st;
    logic last;
    logic [3:0] exp_alu;
    logic exp_src;
    cls = classify(ins);
    exp_alu = ref_alu(ins);
    exp_src = (cls == 1 || cls == 2 || (cls == 0 && ins[6:0] == 7'b0010011));
    seq = {0, 1};
    if (cls != 4) seq.push_back(2);
    if (cls == 1 || cls == 2) for (int m = 0; m <= waits; m++) seq.push_back(3);
    if (cls == 0 || cls == 1) seq.push_back(4);
    mem_idx = 0;
    for (int k = 0; k < seq.size(); k++) begin
      st = seq[k];
      last = (k == seq.size() - 1);
      instr  = (k == 0) ? ins : $urandom;
      Zero   = (st == 2) ? zero_v : 1'($urandom);
      dReady = (st == 3) ? (mem_idx == waits) : 1'($urandom);
      if (st == 3) mem_idx++;
      @(negedge clk);
      check_eq("state", state, st);
      check_eq("loadPC", loadPC, last);
      check_eq("PCSrc", PCSrc, last && cls == 3 && zero_v);
      check_eq("RegWrite", RegWrite, st == 4);
      check_eq("MemToReg", MemToReg, st == 4 && cls == 1);
      check_eq("MemRead", MemRead, st == 3 && cls == 1);
      check_eq("MemWrite", MemWrite, st == 3 && cls == 2);
      check_eq("illegal", illegal, st == 1 && cls == 4);
      if (st == 0) begin
        check_eq("ALUCtrl_IF", ALUCtrl, 0);
        check_eq("ALUSrc_IF", ALUSrc, 0);
      end else if (cls != 4) begin
        check_eq("ALUCtrl", ALUCtrl, exp_alu);
        check_eq("ALUSrc", ALUSrc, exp_src);
      end
      @(posedge clk);
      #1;
    end
    $display("instr %08h class %0d zero %0d waits %0d cycles %0d alu %04b", ins, cls, zero_v, waits, seq.size(), exp_alu);
  endtask

  initial begin
    rst = 1'b1;
    instr = $urandom;
    Zero = 1'b0;
    dReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", state, 0);
    check_eq("rst_outs", {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, illegal}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(32'h002081B3, 1'b0, 0);  // ADD
    run_instr(32'h402081B3, 1'b0, 0);  // SUB
    run_instr(32'h4030D093, 1'b0, 0);  // SRAI
    run_instr(32'h40000093, 1'b0, 0);  // ADDI with bit30 set
    run_instr(32'h0000A103, 1'b0, 3);  // LW, 3 wait cycles
    run_instr(32'h0020A023, 1'b0, 0);  // SW, ready on entry
    run_instr(32'h00208463, 1'b1, 0);  // BEQ taken
    run_instr(32'h00208463, 1'b0, 0);  // BEQ not taken
    run_instr(32'h0000007F, 1'b0, 0);  // illegal opcode
    run_instr(32'h0020B1B3, 1'b0, 0);  // SLTU is illegal

    // Reset during a LW MEM wait
    instr = 32'h0000A103;
    dReady = 1'b0;
    @(negedge clk); check_eq("mr_if", state, 0);
    @(posedge clk); #1; instr = $urandom;
    @(negedge clk); check_eq("mr_id", state, 1);
    @(posedge clk); #1;
    @(negedge clk); check_eq("mr_ex", state, 2);
    @(posedge clk); #1;
    @(negedge clk); check_eq("mr_mem", state, 3); check_eq("mr_memread", MemRead, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); check_eq("mr_hold", state, 3);
    @(posedge clk); #1; dReady = 1'b1;
    @(negedge clk);
    check_eq("mr_rst_state", state, 0);
    check_eq("mr_rst_memread", MemRead, 0);
    check_eq("mr_rst_loadpc", loadPC, 0);
    check_eq("mr_rst_regwrite", RegWrite, 0);
    $display("instr 0000a103 reset during MEM wait");
    @(posedge clk); #1; rst = 1'b0;

    for (int n = 0; n < 300; n++) begin
      run_instr(gen_instr(), 1'($urandom), int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
